// File: rtl/apb_mem_pkg.sv
// Shared types and default widths for the APB-to-memory completer.
package apb_mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    ERROR  = 3'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic logic in_range(
    input logic [31:0] a,
    input int          depth
  );
    return a < 32'(depth);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB completer-side bus bundle with requester and completer views.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [1:0]            id;
  logic                  sel;
  logic                  enable;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  slverr;

  modport master (
    output id, sel, enable, write, addr, wdata,
    input  rdata, ready, slverr
  );

  modport slave (
    input  id, sel, enable, write, addr, wdata,
    output rdata, ready, slverr
  );

endinterface

// File: rtl/apb_mem_slave.sv
// APB completer bridging single transfers onto a ce/rden/wren memory
// bus; memory wait states stretch pready, out-of-range gives pslverr.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = 256,
  parameter int SLAVE_ID   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  apb_mem_slave_if.slave        bus,
  output logic                  mem_ce,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [2:0]            state
);

  state_t                cur;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_write;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic selected;
  logic setup;
  logic done;
  logic in_acc;

  assign selected = bus.sel && (bus.id == 2'(SLAVE_ID));
  assign setup    = selected && !bus.enable;
  assign done     = selected && bus.enable && mem_ready;
  assign in_acc   = (cur == ACCESS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (cur)
        IDLE: begin
          if (setup) begin
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_write <= bus.write;
            cur <= in_range(32'(bus.addr), MEM_DEPTH)
                   ? ACCESS : ERROR;
          end
        end
        ACCESS: begin
          if (!selected) begin
            cur <= IDLE;
          end else if (done) begin
            if (!lat_write) rdata_q <= mem_rdata;
            cur <= IDLE;
          end
        end
        ERROR: begin
          if (!selected || bus.enable) cur <= IDLE;
        end
        default: cur <= IDLE;
      endcase
    end
  end

  // Strobes follow the state directly so an abort or reset drops them at once.
  assign mem_ce    = in_acc;
  assign mem_wren  = in_acc && lat_write;
  assign mem_rden  = in_acc && !lat_write;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_comb begin
    bus.ready  = 1'b0;
    bus.slverr = 1'b0;
    unique case (1'b1)
      (cur == ACCESS): bus.ready = bus.enable && mem_ready;
      (cur == ERROR): begin
        bus.ready  = bus.enable;
        bus.slverr = bus.enable;
      end
      default: ;
    endcase
  end

  assign bus.rdata = (in_acc && !lat_write) ? mem_rdata : rdata_q;
  assign state     = cur;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave with a read-data scoreboard queue.
module tb_apb_mem_slave;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          mem_ce;
  logic          mem_rden;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [2:0]    state;
  logic          mem_clr;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd;

  int n_cmp;
  int n_err;

  apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_mem_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .SLAVE_ID  (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_ce   (mem_ce),
    .mem_rden (mem_rden),
    .mem_wren (mem_wren),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_ce && mem_wren && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int nwait);
    logic          err;
    logic [DW-1:0] exp;
    err = (32'(a) >= DEPTH);
    if (!wr) exp_q.push_back(err ? last_rd : ref_mem[a]);
    @(negedge clk);
    bus.id     = 2'd1;
    bus.sel    = 1'b1;
    bus.enable = 1'b0;
    bus.write  = wr;
    bus.addr   = a;
    bus.wdata  = d;
    mem_ready  = (nwait == 0);
    @(negedge clk);
    #1 chk("state_after_setup", state, err ? 3'd2 : 3'd1);
    bus.enable = 1'b1;
    for (int w = 0; w < nwait; w++) begin
      #1;
      chk("wait_ready", bus.ready, 1'b0);
      chk("wait_ce", mem_ce, !err);
      chk("wait_wren", mem_wren, wr && !err);
      chk("wait_state", state, err ? 3'd2 : 3'd1);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    chk("en_ready", bus.ready, 1'b1);
    chk("en_slverr", bus.slverr, err);
    chk("en_ce", mem_ce, !err);
    if (!err) chk("en_addr", mem_addr, a);
    if (!err) chk("en_rden", mem_rden, !wr);
    if (wr && !err) chk("en_wdata", mem_wdata, d);
    if (!wr) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        chk("en_rdata", bus.rdata, exp);
        last_rd = exp;
      end
    end
    @(negedge clk);
    bus.sel    = 1'b0;
    bus.enable = 1'b0;
    #1;
    chk("state_idle", state, 3'd0);
    chk("idle_ce", mem_ce, 1'b0);
    if (wr && !err) begin
      ref_mem[a] = d;
      chk("mem_written", mem[a], d);
    end
    if (wr && err) chk("mem_untouched", mem[a], ref_mem[a]);
    if (!wr) chk("rdata_held", bus.rdata, last_rd);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    last_rd    = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    mem_clr    = 1'b1;
    reset      = 1'b1;
    bus.id     = 2'd0;
    bus.sel    = 1'b0;
    bus.enable = 1'b0;
    bus.write  = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    mem_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_slverr", bus.slverr, 1'b0);
    chk("rst_ce", mem_ce, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h00);
    reset   = 1'b0;
    mem_clr = 1'b0;

    xfer(1'b1, 8'd6, 8'd5, 0);
    xfer(1'b0, 8'd6, 8'd0, 0);
    xfer(1'b1, 8'd5, 8'd4, 5);
    xfer(1'b0, 8'd5, 8'd0, 5);
    xfer(1'b1, 8'd4, 8'd3, 1);
    xfer(1'b0, 8'd4, 8'd0, 1);
    xfer(1'b1, 8'd3, 8'd2, 3);
    xfer(1'b0, 8'd3, 8'd0, 3);

    xfer(1'b1, 8'd20, 8'd9, 0);
    xfer(1'b0, 8'd20, 8'd0, 0);

    // Another completer's id: nothing may happen here.
    @(negedge clk);
    bus.id     = 2'd2;
    bus.sel    = 1'b1;
    bus.write  = 1'b1;
    bus.addr   = 8'd7;
    bus.wdata  = 8'd7;
    @(negedge clk);
    chk("nsel_state_setup", state, 3'd0);
    chk("nsel_ce_setup", mem_ce, 1'b0);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("nsel_state_en", state, 3'd0);
    chk("nsel_ready", bus.ready, 1'b0);
    bus.sel    = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    chk("nsel_mem", mem[7], 8'd0);

    // Abort: sel dropped while the memory stalls.
    bus.id     = 2'd1;
    bus.sel    = 1'b1;
    bus.write  = 1'b1;
    bus.addr   = 8'd8;
    bus.wdata  = 8'd9;
    mem_ready  = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    #1 chk("abort_in_access", state, 3'd1);
    @(negedge clk);
    bus.sel    = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_state", state, 3'd0);
    chk("abort_ce", mem_ce, 1'b0);
    chk("abort_mem", mem[8], 8'd0);

    // Reset in the middle of a stalled write.
    @(negedge clk);
    bus.sel    = 1'b1;
    bus.write  = 1'b1;
    bus.addr   = 8'd9;
    bus.wdata  = 8'd1;
    @(negedge clk);
    bus.enable = 1'b1;
    #1 chk("mid_ce_before", mem_ce, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_state", state, 3'd0);
    chk("mid_rst_ready", bus.ready, 1'b0);
    chk("mid_rst_ce", mem_ce, 1'b0);
    chk("mid_rst_rdata", bus.rdata, 8'h00);
    mem_ready  = 1'b1;
    bus.sel    = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_mem", mem[9], 8'd0);
    last_rd = '0;

    xfer(1'b0, 8'd6, 8'd0, 2);
    xfer(1'b0, 8'd15, 8'd0, 0);
    xfer(1'b0, 8'd16, 8'd0, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
